// File: rtl/frame_tx_scheduler_if.sv
// Byte-stream handshake between the frame scheduler and the UART transmitter.
// A byte transfers on any clock edge where tx_valid and tx_ready are both high.
interface frame_tx_scheduler_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  // Byte source (scheduler side)
  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  // Byte sink (UART side)
  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/frame_tx_scheduler.sv
// Snapshots the pong game state on request and streams it to the UART as a
// 7-byte frame: header, ball x/y, paddle rows, packed scores, XOR checksum.
// All state is captured in one cycle so a frame is never torn.
module frame_tx_scheduler #(
  parameter logic [7:0]  HEADER = 8'hA5,
  parameter int unsigned OVR_W  = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tick,
  input  logic [7:0]          ball_x,
  input  logic [7:0]          ball_y,
  input  logic [7:0]          paddle_0_x,
  input  logic [7:0]          paddle_1_x,
  input  logic [3:0]          score_0,
  input  logic [3:0]          score_1,
  frame_tx_scheduler_if.master tx,
  output logic                busy,
  output logic                frame_done,
  output logic [OVR_W-1:0]    overrun_count
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  localparam logic [2:0]       LastIdx = 3'd6;
  localparam logic [OVR_W-1:0] OvrMax  = {OVR_W{1'b1}};

  state_e           state_q;
  logic [2:0]       idx_q;
  logic [7:0]       tx_data_q;
  logic             tx_valid_q;
  logic             busy_q;
  logic             frame_done_q;
  logic             pending_q;
  logic [OVR_W-1:0] overrun_q;

  // Snapshot of the frame payload (B1..B6)
  logic [7:0] snap_ball_x_q;
  logic [7:0] snap_ball_y_q;
  logic [7:0] snap_paddle_0_q;
  logic [7:0] snap_paddle_1_q;
  logic [7:0] snap_score_q;
  logic [7:0] snap_chk_q;

  logic [7:0] score_byte;
  logic [7:0] checksum;
  logic       accept;
  logic       last_accept;
  logic       start_req;
  logic       capture;
  logic [2:0] idx_next;
  logic [7:0] next_byte;

  // Capture-side payload and the handshake/sequencing decisions
  always_comb begin
    score_byte  = {score_0, score_1};
    checksum    = ball_x ^ ball_y ^ paddle_0_x ^ paddle_1_x ^ score_byte;
    accept      = tx_valid_q & tx.tx_ready;
    last_accept = (state_q == StSend) && accept && (idx_q == LastIdx);
    start_req   = tick | pending_q;
    // A new snapshot starts from idle, or back to back as the last byte leaves
    capture     = start_req && ((state_q == StIdle) || last_accept);
    idx_next    = idx_q + 3'd1;
  end

  // Byte to present once the current byte has been accepted
  always_comb begin
    next_byte = 8'h00;
    case (idx_next)
      3'd1:    next_byte = snap_ball_x_q;
      3'd2:    next_byte = snap_ball_y_q;
      3'd3:    next_byte = snap_paddle_0_q;
      3'd4:    next_byte = snap_paddle_1_q;
      3'd5:    next_byte = snap_score_q;
      3'd6:    next_byte = snap_chk_q;
      default: next_byte = 8'h00;
    endcase
  end

  // Frame FSM with registered outputs, snapshot and overrun tracking
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= StIdle;
      idx_q           <= 3'd0;
      tx_data_q       <= 8'h00;
      tx_valid_q      <= 1'b0;
      busy_q          <= 1'b0;
      frame_done_q    <= 1'b0;
      pending_q       <= 1'b0;
      overrun_q       <= '0;
      snap_ball_x_q   <= 8'h00;
      snap_ball_y_q   <= 8'h00;
      snap_paddle_0_q <= 8'h00;
      snap_paddle_1_q <= 8'h00;
      snap_score_q    <= 8'h00;
      snap_chk_q      <= 8'h00;
    end else begin
      frame_done_q <= last_accept;
      if (capture) begin
        // Any tick this cycle is consumed by the capture itself
        snap_ball_x_q   <= ball_x;
        snap_ball_y_q   <= ball_y;
        snap_paddle_0_q <= paddle_0_x;
        snap_paddle_1_q <= paddle_1_x;
        snap_score_q    <= score_byte;
        snap_chk_q      <= checksum;
        pending_q       <= 1'b0;
        idx_q           <= 3'd0;
        tx_data_q       <= HEADER;
        tx_valid_q      <= 1'b1;
        busy_q          <= 1'b1;
        state_q         <= StSend;
      end else if (state_q == StSend) begin
        if (tick) begin
          if (!pending_q) begin
            pending_q <= 1'b1;
          end else if (overrun_q != OvrMax) begin
            overrun_q <= overrun_q + OVR_W'(1);
          end
        end
        if (accept) begin
          if (idx_q == LastIdx) begin
            idx_q      <= 3'd0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= StIdle;
          end else begin
            idx_q     <= idx_next;
            tx_data_q <= next_byte;
          end
        end
      end
    end
  end

  assign tx.tx_data    = tx_data_q;
  assign tx.tx_valid   = tx_valid_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign overrun_count = overrun_q;

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// Directed bench for frame_tx_scheduler: frame contents, back-pressure,
// snapshot isolation, back-to-back frames, overrun saturation and mid-frame reset.
module tb_frame_tx_scheduler;

  logic       clock;
  logic       reset;
  logic       tick;
  logic [7:0] ball_x;
  logic [7:0] ball_y;
  logic [7:0] paddle_0_x;
  logic [7:0] paddle_1_x;
  logic [3:0] score_0;
  logic [3:0] score_1;
  logic       busy;
  logic       frame_done;
  logic [7:0] overrun_count;
  logic       busy_s;
  logic       frame_done_s;
  logic [1:0] overrun_count_s;

  int checks = 0;
  int errors = 0;

  frame_tx_scheduler_if tx_if ();
  frame_tx_scheduler_if tx_s ();

  frame_tx_scheduler u_dut (
    .clock         (clock),
    .reset         (reset),
    .tick          (tick),
    .ball_x        (ball_x),
    .ball_y        (ball_y),
    .paddle_0_x    (paddle_0_x),
    .paddle_1_x    (paddle_1_x),
    .score_0       (score_0),
    .score_1       (score_1),
    .tx            (tx_if),
    .busy          (busy),
    .frame_done    (frame_done),
    .overrun_count (overrun_count)
  );

  // Narrow overrun counter copy, driven identically, to see saturation
  frame_tx_scheduler #(.OVR_W(2)) u_dut_sat (
    .clock         (clock),
    .reset         (reset),
    .tick          (tick),
    .ball_x        (ball_x),
    .ball_y        (ball_y),
    .paddle_0_x    (paddle_0_x),
    .paddle_1_x    (paddle_1_x),
    .score_0       (score_0),
    .score_1       (score_1),
    .tx            (tx_s),
    .busy          (busy_s),
    .frame_done    (frame_done_s),
    .overrun_count (overrun_count_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [55:0] FrameA = 56'hA5_29_0C_05_4B_37_5C;
  localparam logic [55:0] FrameB = 56'hA5_63_0C_05_4B_37_16;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ready(input logic r);
    tx_if.tx_ready = r;
    tx_s.tx_ready  = r;
  endtask

  // Called #1 after the capture edge; walks the frame following the ready
  // and tick patterns (bit n used on cycle n) and ends #1 after the last accept.
  task automatic run_frame(input logic [55:0] e, input logic [15:0] rdy_pat,
                           input logic [15:0] tick_pat, input int chg_cyc);
    int   k;
    int   cyc;
    logic r;
    k   = 0;
    cyc = 0;
    while (k < 7 && cyc < 40) begin
      check("frame_valid", {31'b0, tx_if.tx_valid}, 32'd1);
      check("frame_byte", {24'b0, tx_if.tx_data}, {24'b0, e[55-8*k -: 8]});
      if (cyc == chg_cyc) ball_x = 8'd99;
      r    = rdy_pat[cyc % 16];
      tick = tick_pat[cyc % 16];
      set_ready(r);
      step();
      if (r) k++;
      cyc++;
    end
    tick = 1'b0;
    check("frame_complete", k, 32'd7);
  endtask

  task automatic check_idle_end(input string tag);
    check({tag, "_done"}, {31'b0, frame_done}, 32'd1);
    check({tag, "_valid"}, {31'b0, tx_if.tx_valid}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    step();
    check({tag, "_done_pulse"}, {31'b0, frame_done}, 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    tick       = 1'b0;
    ball_x     = 8'd41;
    ball_y     = 8'd12;
    paddle_0_x = 8'd5;
    paddle_1_x = 8'd75;
    score_0    = 4'd3;
    score_1    = 4'd7;
    set_ready(1'b1);
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_valid", {31'b0, tx_if.tx_valid}, 32'd0);
    check("rst_data", {24'b0, tx_if.tx_data}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, frame_done}, 32'd0);
    check("rst_ovr", {24'b0, overrun_count}, 32'd0);

    // Ready with nothing valid does nothing
    step();
    step();
    check("idle_ready_valid", {31'b0, tx_if.tx_valid}, 32'd0);

    // T1: single frame at full rate
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("t1_busy", {31'b0, busy}, 32'd1);
    run_frame(FrameA, 16'hFFFF, 16'h0000, -1);
    check_idle_end("t1");

    // T2: back-pressure pattern 1,0,0,1
    tick = 1'b1;
    step();
    tick = 1'b0;
    run_frame(FrameA, 16'h9999, 16'h0000, -1);
    check_idle_end("t2");
    set_ready(1'b1);

    // T3: ball_x changes after B1 accepted; frame keeps snapshot
    tick = 1'b1;
    step();
    tick = 1'b0;
    run_frame(FrameA, 16'hFFFF, 16'h0000, 2);
    check_idle_end("t3a");
    tick = 1'b1;
    step();
    tick = 1'b0;
    run_frame(FrameB, 16'hFFFF, 16'h0000, -1);
    check_idle_end("t3b");

    // T4: one tick mid-frame gives a back-to-back frame
    tick = 1'b1;
    step();
    tick = 1'b0;
    run_frame(FrameB, 16'hFFFF, 16'h0008, -1);
    check("t4_done", {31'b0, frame_done}, 32'd1);
    check("t4_busy", {31'b0, busy}, 32'd1);
    check("t4_ovr", {24'b0, overrun_count}, 32'd0);
    run_frame(FrameB, 16'hFFFF, 16'h0000, -1);
    check_idle_end("t4");

    // T5: three ticks, then four more; narrow counter saturates
    tick = 1'b1;
    step();
    tick = 1'b0;
    run_frame(FrameB, 16'hFFFF, 16'h000E, -1);
    check("t5_ovr_a", {24'b0, overrun_count}, 32'd2);
    check("t5_ovr_sat_a", {30'b0, overrun_count_s}, 32'd2);
    run_frame(FrameB, 16'hFFFF, 16'h001E, -1);
    check("t5_ovr_b", {24'b0, overrun_count}, 32'd5);
    check("t5_ovr_sat_b", {30'b0, overrun_count_s}, 32'd3);
    run_frame(FrameB, 16'hFFFF, 16'h0000, -1);
    check_idle_end("t5");

    // T6: reset while B3 is on the bus
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    step();
    step();
    check("t6_b3", {24'b0, tx_if.tx_data}, 32'h05);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_valid", {31'b0, tx_if.tx_valid}, 32'd0);
    check("t6_busy", {31'b0, busy}, 32'd0);
    check("t6_done", {31'b0, frame_done}, 32'd0);
    check("t6_ovr", {24'b0, overrun_count}, 32'd0);
    step();
    check("t6_done_after", {31'b0, frame_done}, 32'd0);
    check("t6_idle_valid", {31'b0, tx_if.tx_valid}, 32'd0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    run_frame(FrameB, 16'hFFFF, 16'h0000, -1);
    check_idle_end("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
